// File: rtl/aibcr3_dcc_cal_pkg.sv
// Shared types for the DCC calibration sequencer: FSM state encoding and retry counter width.
package aibcr3_dcc_cal_pkg;

  localparam int RETRY_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    WAIT   = 3'd2,
    DROP   = 3'd3,
    SETTLE = 3'd4,
    LOCKED = 3'd5,
    FAIL   = 3'd6
  } cal_state_t;

endpackage

// File: rtl/aibcr3_dcc_cal_sync.sv
// Two-flop synchronizer bringing the DCC-domain done flag into the calibration clock domain.
module aibcr3_dcc_cal_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aibcr3_dcc_cal_ctrl.sv
// DCC calibration sequencer: request/timeout/retry FSM with registered status outputs.
// Periodic recalibration from LOCKED is built only when AIBCR3_DCC_RECAL_EN is defined.
module aibcr3_dcc_cal_ctrl
  import aibcr3_dcc_cal_pkg::*;
#(
  parameter int              TMO_W      = 16,
  parameter logic [TMO_W-1:0] TMO_CYC    = 16'd4096,
  parameter logic [TMO_W-1:0] SETTLE_CYC = 16'd64,
  parameter logic [TMO_W-1:0] DROP_CYC   = 16'd8,
  parameter int unsigned     MAX_RETRY  = 3,
  parameter int              RECAL_W    = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cal_start,
  input  logic               cal_abort,
  input  logic               cont_cal_en,
  input  logic [RECAL_W-1:0] recal_period,
  input  logic               dcc_done,
  output logic               dcc_req,
  output logic               cal_busy,
  output logic               cal_done,
  output logic               cal_fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lost_lock
);

  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_CYC - TMO_W'(1);
  localparam logic [TMO_W-1:0] SETTLE_LAST = SETTLE_CYC - TMO_W'(1);
  localparam logic [TMO_W-1:0] DROP_LAST   = DROP_CYC - TMO_W'(1);

  cal_state_t       state;
  cal_state_t       state_nxt;
  cal_state_t       retry_state;
  logic [TMO_W-1:0] tmr;
  logic [TMO_W-1:0] drop_cnt;
  logic [TMO_W-1:0] settle_cnt;
  logic             done_s;
  logic             retry_ok;
  logic             retry_inc;
  logic             retry_clr;
  logic             lost_set;
  logic             lost_clr;
  logic             recal_hit;

  aibcr3_dcc_cal_sync u_done_sync (
    .clk (clk),
    .rst (rst),
    .d   (dcc_done),
    .q   (done_s)
  );

  // A failed attempt (timeout, settle glitch, lock loss) either retries through DROP or gives up.
  assign retry_ok    = (retry_cnt < RETRY_W'(MAX_RETRY));
  assign retry_state = retry_ok ? DROP : FAIL;

`ifdef AIBCR3_DCC_RECAL_EN
  logic [RECAL_W-1:0] recal_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      recal_cnt <= '0;
    end else if (state == LOCKED && state_nxt == LOCKED) begin
      recal_cnt <= recal_cnt + RECAL_W'(~&recal_cnt);
    end else begin
      recal_cnt <= '0;
    end
  end

  assign recal_hit = cont_cal_en && (recal_period != '0) &&
                     (recal_cnt == recal_period - RECAL_W'(1));
`else
  logic unused_recal;
  assign unused_recal = cont_cal_en ^ (^recal_period);
  assign recal_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    lost_set  = 1'b0;
    lost_clr  = 1'b0;
    if (cal_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, FAIL: begin
          if (cal_start) begin
            state_nxt = ARM;
            lost_clr  = 1'b1;
          end
        end
        ARM: begin
          state_nxt = WAIT;
          retry_clr = 1'b1;
        end
        WAIT: begin
          if (done_s) begin
            state_nxt = SETTLE;
          end else if (tmr == TMO_LAST) begin
            state_nxt = retry_state;
            retry_inc = retry_ok;
          end
        end
        DROP: begin
          if (drop_cnt == DROP_LAST) state_nxt = WAIT;
        end
        SETTLE: begin
          if (!done_s) begin
            state_nxt = retry_state;
            retry_inc = retry_ok;
          end else if (settle_cnt == SETTLE_LAST) begin
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (!done_s) begin
            lost_set  = 1'b1;
            state_nxt = retry_state;
            retry_inc = retry_ok;
          end else if (recal_hit) begin
            state_nxt = DROP;
            retry_clr = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decode the state being entered so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dcc_req    <= 1'b0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_fail   <= 1'b0;
      retry_cnt  <= '0;
      lost_lock  <= 1'b0;
      tmr        <= '0;
      drop_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      dcc_req  <= (state_nxt == WAIT) || (state_nxt == SETTLE) || (state_nxt == LOCKED);
      cal_busy <= (state_nxt == ARM) || (state_nxt == WAIT) ||
                  (state_nxt == DROP) || (state_nxt == SETTLE);
      cal_done <= (state_nxt == LOCKED);
      cal_fail <= (state_nxt == FAIL);

      tmr        <= (state == WAIT && state_nxt == WAIT) ?
                    tmr + TMO_W'(~&tmr) : '0;
      drop_cnt   <= (state == DROP && state_nxt == DROP) ?
                    drop_cnt + TMO_W'(~&drop_cnt) : '0;
      settle_cnt <= (state == SETTLE && state_nxt == SETTLE) ?
                    settle_cnt + TMO_W'(~&settle_cnt) : '0;

      if (retry_clr) begin
        retry_cnt <= '0;
      end else if (retry_inc && retry_cnt != '1) begin
        retry_cnt <= retry_cnt + RETRY_W'(1);
      end

      if (lost_clr) begin
        lost_lock <= 1'b0;
      end else if (lost_set) begin
        lost_lock <= 1'b1;
      end
    end
  end

endmodule
